operand_issue_stage: RTL and testbench
======================================

// Module: operand_issue_stage
// PURPOSE
//  ID->EX operand stage directly downstream of the 32x32 register file.
//  Takes the register file's asynchronous read data rd1/rd2 and resolves RAW
//  hazards by forwarding from the MEM and WB stages. Detects load-use hazards
//  and stalls ID. Latches operands and control into the ID/EX pipeline
//  register, with hold, flush and bubble insertion.
// PARAMETERS
//  WIDTH  32  datapath width (operands, immediate, forwarded data)
//  AW     5   register address width; register 0 reads as 0 and never forwards
// PORTS
//  clk         in   1      clock, all state updates on posedge
//  rst         in   1      synchronous reset, active-high
//  id_valid    in   1      ID holds a real instruction
//  id_ra1      in   AW     source reg 1, also drives regfile ra1
//  id_ra2      in   AW     source reg 2, also drives regfile ra2
//  id_rd1      in   WIDTH  regfile read data 1
//  id_rd2      in   WIDTH  regfile read data 2
//  id_imm      in   WIDTH  sign/zero-extended immediate
//  id_wa       in   AW     destination register
//  id_we       in   1      instruction writes id_wa
//  id_load     in   1      instruction is a load (result available after MEM)
//  mem_we      in   1      MEM stage write enable
//  mem_wa      in   AW     MEM stage destination
//  mem_wd      in   WIDTH  MEM stage ALU result
//  wb_we       in   1      WB stage write enable (same signal as regfile we)
//  wb_wa       in   AW     WB stage destination (regfile wa)
//  wb_wd       in   WIDTH  WB stage data (regfile wd)
//  ex_hold     in   1      downstream busy: freeze the EX register
//  flush       in   1      squash the instruction currently in ID
//  stall_id    out  1      freeze PC and IF/ID this cycle (combinational)
//  ex_valid    out  1      EX register holds a real instruction
//  ex_a        out  WIDTH  resolved operand 1
//  ex_b        out  WIDTH  resolved operand 2
//  ex_imm      out  WIDTH  latched immediate
//  ex_wa       out  AW     latched destination
//  ex_we       out  1      latched write enable, forced 0 when !ex_valid
//  ex_load     out  1      latched load flag, forced 0 when !ex_valid
// BEHAVIOUR
//  - Reset: all ex_* outputs are 0. stall_id = 0 while rst is high.
//  - Operand select for each source s, in priority order:
//    s==0 -> 0
//    mem_we && mem_wa==s -> mem_wd
//    WB bypass (see CONFIGURATION)
//    otherwise -> id_rdN.
//  - Load-use hazard: ex_valid && ex_load && ex_wa!=0 && ex_wa in {ra1,ra2}
//    && id_valid. Result is stall_id=1; the EX register takes a bubble.
//    Lasts exactly 1 cycle.
//  - stall_id = ex_hold | load_use | wb_hazard (wb_hazard only without macro).
//  - EX register update at posedge, in priority order:
//    rst -> clear
//    ex_hold -> keep all contents (flush still reported to ID, not applied here)
//    flush, load_use or wb_hazard -> bubble (ex_valid=0, ex_we=0, ex_load=0)
//    otherwise -> latch (ex_valid=id_valid, resolved operands, id_* control).
//  - Bubble data fields (a, b, imm, wa) are don't-care; the bench checks only
//    the valid, we and load fields.
//  - Latency is 1 cycle from ID inputs to ex_* outputs. There is no wrap or
//    overflow; data passes through unmodified.
//  - A rst asserted while held or stalled clears everything on the next edge.
// CONFIGURATION
//  WB_BYPASS_EN defined:
//   wb_we && wb_wa==s (s!=0) selects wb_wd, below MEM and above the regfile.
//   No wb_hazard; a same-cycle WB write causes no stall.
//  WB_BYPASS_EN undefined:
//   No WB forwarding. wb_hazard = id_valid && wb_we && wb_wa!=0 && wb_wa
//   matches a source not already covered by MEM forwarding. It inserts 1 bubble
//   and the regfile is reread next cycle, after its posedge write has landed.
// TESTING
//  1 rst=1 for 2 cycles, then id_valid=1, ra1=3, rd1=0x11 -> ex_valid=1,
//    ex_a=0x11 after 1 edge; during reset all ex_*=0.
//  2 ra1=5, mem_we=1, mem_wa=5, mem_wd=0xAA, and wb also writes r5=0xBB
//    -> ex_a=0xAA (MEM wins).
//  3 EX holds a load with wa=7; ID reads ra2=7 -> stall_id=1 for 1 cycle,
//    bubble (ex_valid=0); next cycle ex_b takes mem_wd.
//  4 ra1=0, mem_wa=0, mem_we=1, mem_wd=0xFF -> ex_a=0.
//  5 ex_hold=1 for 3 cycles with new ID data -> ex_* unchanged, stall_id=1;
//    assert flush on cycle 2 -> after release, EX latches current ID.
//  6 wb_we=1, wb_wa=4, wb_wd=0x44, ra1=4, rd1=old 0x40:
//    with the macro -> ex_a=0x44, no stall;
//    without -> stall_id=1, one bubble, then ex_a=0x44.

Source files
------------

// File: rtl/operand_issue_stage.sv
// ID->EX operand stage: forwards MEM/WB results over the regfile read data, detects
// load-use and WB-write hazards, and registers operands/control into ID/EX.
// Optional macro WB_BYPASS_EN: forward WB data instead of stalling on a same-cycle WB write.
module operand_issue_stage #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [AW-1:0]    id_ra1,
  input  logic [AW-1:0]    id_ra2,
  input  logic [WIDTH-1:0] id_rd1,
  input  logic [WIDTH-1:0] id_rd2,
  input  logic [WIDTH-1:0] id_imm,
  input  logic [AW-1:0]    id_wa,
  input  logic             id_we,
  input  logic             id_load,
  input  logic             mem_we,
  input  logic [AW-1:0]    mem_wa,
  input  logic [WIDTH-1:0] mem_wd,
  input  logic             wb_we,
  input  logic [AW-1:0]    wb_wa,
  input  logic [WIDTH-1:0] wb_wd,
  input  logic             ex_hold,
  input  logic             flush,
  output logic             stall_id,
  output logic             ex_valid,
  output logic [WIDTH-1:0] ex_a,
  output logic [WIDTH-1:0] ex_b,
  output logic [WIDTH-1:0] ex_imm,
  output logic [AW-1:0]    ex_wa,
  output logic             ex_we,
  output logic             ex_load
);

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             load_use;
  logic             wb_hazard;
  logic             mem_hit1;
  logic             mem_hit2;

  assign mem_hit1 = mem_we && (mem_wa == id_ra1);
  assign mem_hit2 = mem_we && (mem_wa == id_ra2);

  // Priority: r0, then MEM, then (optionally) WB, then the regfile value.
  function automatic logic [WIDTH-1:0] resolve(
    input logic [AW-1:0]    src,
    input logic [WIDTH-1:0] rd,
    input logic             mem_hit
  );
    logic [WIDTH-1:0] res;
    res = rd;
    if (src == '0) begin
      res = '0;
    end else if (mem_hit) begin
      res = mem_wd;
`ifdef WB_BYPASS_EN
    end else if (wb_we && (wb_wa == src)) begin
      res = wb_wd;
`endif
    end
    return res;
  endfunction

  always_comb begin
    op_a = resolve(id_ra1, id_rd1, mem_hit1);
    op_b = resolve(id_ra2, id_rd2, mem_hit2);
  end

  assign load_use = id_valid && ex_valid && ex_load && (ex_wa != '0) &&
                    ((ex_wa == id_ra1) || (ex_wa == id_ra2));

`ifdef WB_BYPASS_EN
  assign wb_hazard = 1'b0;
`else
  // The regfile write lands at this edge; re-reading next cycle picks it up.
  assign wb_hazard = id_valid && wb_we && (wb_wa != '0) &&
                     (((wb_wa == id_ra1) && !mem_hit1) ||
                      ((wb_wa == id_ra2) && !mem_hit2));
  logic unused_wb_wd;
  assign unused_wb_wd = ^wb_wd;
`endif

  assign stall_id = !rst && (ex_hold || load_use || wb_hazard);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the data fields are cleared too so reset shows all zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid <= 1'b0;
      ex_a     <= '0;
      ex_b     <= '0;
      ex_imm   <= '0;
      ex_wa    <= '0;
      ex_we    <= 1'b0;
      ex_load  <= 1'b0;
    end else if (ex_hold) begin
      // Frozen: a flush here is handled upstream by squashing ID.
    end else if (flush || load_use || wb_hazard) begin
      ex_valid <= 1'b0;
      ex_we    <= 1'b0;
      ex_load  <= 1'b0;
    end else begin
      ex_valid <= id_valid;
      ex_a     <= op_a;
      ex_b     <= op_b;
      ex_imm   <= id_imm;
      ex_wa    <= id_wa;
      ex_we    <= id_valid && id_we;
      ex_load  <= id_valid && id_load;
    end
  end

endmodule

// File: tb/tb_operand_issue_stage.sv
// Scoreboard bench for operand_issue_stage: directed scenarios then random traffic,
// checked against a behavioural model including a register-file array.
module tb_operand_issue_stage;

  localparam int WIDTH = 32;
  localparam int AW    = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             id_valid = 1'b0;
  logic [AW-1:0]    id_ra1 = '0, id_ra2 = '0, id_wa = '0;
  logic [WIDTH-1:0] id_rd1 = '0, id_rd2 = '0, id_imm = '0;
  logic             id_we = 1'b0, id_load = 1'b0;
  logic             mem_we = 1'b0;
  logic [AW-1:0]    mem_wa = '0;
  logic [WIDTH-1:0] mem_wd = '0;
  logic             wb_we = 1'b0;
  logic [AW-1:0]    wb_wa = '0;
  logic [WIDTH-1:0] wb_wd = '0;
  logic             ex_hold = 1'b0, flush = 1'b0;
  logic             stall_id, ex_valid, ex_we, ex_load;
  logic [WIDTH-1:0] ex_a, ex_b, ex_imm;
  logic [AW-1:0]    ex_wa;

  operand_issue_stage #(.WIDTH(WIDTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ra1(id_ra1), .id_ra2(id_ra2),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_wa(id_wa), .id_we(id_we),
    .id_load(id_load), .mem_we(mem_we), .mem_wa(mem_wa), .mem_wd(mem_wd),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd), .ex_hold(ex_hold), .flush(flush),
    .stall_id(stall_id), .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b),
    .ex_imm(ex_imm), .ex_wa(ex_wa), .ex_we(ex_we), .ex_load(ex_load)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             rst, hold, flush;
    logic             id_valid, we, load;
    logic [AW-1:0]    ra1, ra2, wa;
    logic [WIDTH-1:0] imm;
    logic             mem_we;
    logic [AW-1:0]    mem_wa;
    logic [WIDTH-1:0] mem_wd;
    logic             wb_we;
    logic [AW-1:0]    wb_wa;
    logic [WIDTH-1:0] wb_wd;
  } stim_t;

  typedef struct {
    logic             valid, we, load, full;
    logic [WIDTH-1:0] a, b, imm;
    logic [AW-1:0]    wa;
  } exp_t;

  exp_t             sb[$];
  exp_t             model;
  logic [WIDTH-1:0] regs[32];
  stim_t            held;
  logic             prev_stall = 1'b0, prev_flush = 1'b0;
  int               n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, required %h", name, $time, act, req);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  // Architectural view: the youngest in-flight producer of src wins, r0 is always zero.
  function automatic logic [WIDTH-1:0] operand(input logic [AW-1:0] src, input stim_t s);
    if (src == 0) return '0;
    if (s.mem_we && s.mem_wa == src) return s.mem_wd;
`ifdef WB_BYPASS_EN
    if (s.wb_we && s.wb_wa == src) return s.wb_wd;
`endif
    return regs[src];
  endfunction

  task automatic step(input stim_t s_in);
    stim_t s;
    logic  lu, wbh, exp_stall;
    exp_t  nx;
    s = s_in;
    // Upstream behaviour: a stalled, unflushed ID instruction is presented again.
    if (prev_stall && !prev_flush) begin
      s.id_valid = held.id_valid; s.ra1 = held.ra1; s.ra2 = held.ra2;
      s.wa = held.wa; s.we = held.we; s.load = held.load; s.imm = held.imm;
    end
    @(negedge clk);
    rst = s.rst; ex_hold = s.hold; flush = s.flush;
    id_valid = s.id_valid; id_ra1 = s.ra1; id_ra2 = s.ra2; id_wa = s.wa;
    id_we = s.we; id_load = s.load; id_imm = s.imm;
    id_rd1 = regs[s.ra1]; id_rd2 = regs[s.ra2];
    mem_we = s.mem_we; mem_wa = s.mem_wa; mem_wd = s.mem_wd;
    wb_we = s.wb_we; wb_wa = s.wb_wa; wb_wd = s.wb_wd;
    #1;
    lu = s.id_valid && model.valid && model.load && model.wa != 0 &&
         (model.wa == s.ra1 || model.wa == s.ra2);
    wbh = 1'b0;
`ifndef WB_BYPASS_EN
    wbh = s.id_valid && s.wb_we && s.wb_wa != 0 &&
          ((s.wb_wa == s.ra1 && !(s.mem_we && s.mem_wa == s.ra1)) ||
           (s.wb_wa == s.ra2 && !(s.mem_we && s.mem_wa == s.ra2)));
`endif
    exp_stall = !s.rst && (s.hold || lu || wbh);
    check("stall_id", {31'b0, stall_id}, {31'b0, exp_stall});
    nx = model;
    nx.full = 1'b0;
    if (s.rst) begin
      nx = '{default: '0};
      nx.full = 1'b1;
    end else if (s.hold) begin
      nx.full = model.valid;
    end else if (s.flush || lu || wbh) begin
      nx.valid = 1'b0; nx.we = 1'b0; nx.load = 1'b0;
    end else begin
      nx.valid = s.id_valid;
      nx.we    = s.id_valid && s.we;
      nx.load  = s.id_valid && s.load;
      nx.a     = operand(s.ra1, s);
      nx.b     = operand(s.ra2, s);
      nx.imm   = s.imm;
      nx.wa    = s.wa;
      nx.full  = s.id_valid;
    end
    sb.push_back(nx);
    model = nx;
    if (s.wb_we && s.wb_wa != 0) regs[s.wb_wa] = s.wb_wd;
    held = s;
    prev_stall = exp_stall;
    prev_flush = s.flush;
  endtask

  // Monitor: one EX snapshot per edge, compared against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("ex_valid", {31'b0, ex_valid}, {31'b0, e.valid});
        check("ex_we", {31'b0, ex_we}, {31'b0, e.we});
        check("ex_load", {31'b0, ex_load}, {31'b0, e.load});
        if (e.full) begin
          check("ex_a", ex_a, e.a);
          check("ex_b", ex_b, e.b);
          check("ex_imm", ex_imm, e.imm);
          check("ex_wa", {27'b0, ex_wa}, {27'b0, e.wa});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    model = '{default: '0};
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = 32'hDEAD_BEEF;

    // Reset for two cycles with hold asserted: stall must stay low.
    s = idle(); s.rst = 1'b1; s.hold = 1'b1;
    step(s); step(s);

    // Preload r3, r4, r5 through the write-back port with ID idle.
    s = idle(); s.wb_we = 1'b1; s.wb_wa = 5'd3; s.wb_wd = 32'h11; step(s);
    s.wb_wa = 5'd4; s.wb_wd = 32'h40; step(s);
    s.wb_wa = 5'd5; s.wb_wd = 32'h55; step(s);

    s = idle(); s.id_valid = 1'b1; s.ra1 = 5'd3; s.imm = 32'h1234; s.wa = 5'd9; s.we = 1'b1;
    step(s);

    s = idle(); s.id_valid = 1'b1; s.ra1 = 5'd5; s.ra2 = 5'd3;
    s.mem_we = 1'b1; s.mem_wa = 5'd5; s.mem_wd = 32'hAA;
    s.wb_we = 1'b1; s.wb_wa = 5'd5; s.wb_wd = 32'hBB;
    step(s);

    // Load into EX, then a consumer of r7: one bubble, then MEM forwarding.
    s = idle(); s.id_valid = 1'b1; s.wa = 5'd7; s.we = 1'b1; s.load = 1'b1; s.ra1 = 5'd1;
    step(s);
    s = idle(); s.id_valid = 1'b1; s.ra1 = 5'd3; s.ra2 = 5'd7; s.wa = 5'd8; s.we = 1'b1;
    step(s);
    s.mem_we = 1'b1; s.mem_wa = 5'd7; s.mem_wd = 32'h77;
    step(s);

    s = idle(); s.id_valid = 1'b1; s.ra1 = 5'd0; s.mem_we = 1'b1; s.mem_wa = 5'd0;
    s.mem_wd = 32'hFF;
    step(s);

    // Hold three cycles with a flush in the middle, then release.
    s = idle(); s.id_valid = 1'b1; s.ra1 = 5'd3; s.wa = 5'd2; s.we = 1'b1; s.imm = 32'h1;
    step(s);
    s.hold = 1'b1; s.imm = 32'h2; step(s);
    s.flush = 1'b1; s.imm = 32'h3; step(s);
    s.flush = 1'b0; s.imm = 32'h4; s.ra1 = 5'd4; step(s);
    s.hold = 1'b0; s.imm = 32'h5; step(s);

    // Same-cycle WB write to a source register.
    s = idle(); s.id_valid = 1'b1; s.ra1 = 5'd4; s.wa = 5'd6; s.we = 1'b1;
    s.wb_we = 1'b1; s.wb_wa = 5'd4; s.wb_wd = 32'h44;
    step(s);
    s = idle(); step(s);
    step(s);

    // Random traffic over a small register window to provoke collisions.
    for (int i = 0; i < 2000; i++) begin
      s.rst      = ($urandom_range(0, 99) == 0);
      s.hold     = ($urandom_range(0, 9) == 0);
      s.flush    = ($urandom_range(0, 9) == 0);
      s.id_valid = ($urandom_range(0, 4) != 0);
      s.we       = $urandom_range(0, 1);
      s.load     = ($urandom_range(0, 2) == 0);
      s.ra1      = AW'($urandom_range(0, 7));
      s.ra2      = AW'($urandom_range(0, 7));
      s.wa       = AW'($urandom_range(0, 7));
      s.imm      = $urandom;
      s.mem_we   = $urandom_range(0, 1);
      s.mem_wa   = AW'($urandom_range(0, 7));
      s.mem_wd   = $urandom;
      s.wb_we    = $urandom_range(0, 1);
      s.wb_wa    = AW'($urandom_range(0, 7));
      s.wb_wd    = $urandom;
      step(s);
    end

    repeat (3) @(posedge clk);
    #2;
    check("sb_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
